console_type_detector: RTL and testbench

- Power-up console classifier for the cartridge top level; supersedes the fixed 4-bit init counter and 2+2 sample probe.
- Holds the shared CIRAM /CE and PPU /A13 lines low for a programmable init period.
- Then probes qualified PPU read events and classifies the console as classic (CIRAM used) or new famiclone (CIRAM/A13 unused).
- Adds a mismatch threshold, probe timeout, force override and re-detect request; all logic is synchronous to m2.

---
 rtl/console_type_detector_if.sv | 26 ++
 rtl/console_type_detector.sv | 104 ++++++++++
 tb/tb_console_type_detector.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/console_type_detector_if.sv
// console_type_detector_if: PPU read probe inputs and console classification status
interface console_type_detector_if #(
    parameter int MCNT_W = 3
);
    logic              rd_evt;
    logic              rd_a13;
    logic              rd_not_a13;
    logic [1:0]        force_mode;
    logic              redetect;
    logic              hold_low;
    logic              probing;
    logic              done;
    logic              new_dendy;
    logic              timed_out;
    logic [MCNT_W-1:0] mismatch_cnt;

    modport master (
        output rd_evt, rd_a13, rd_not_a13, force_mode, redetect,
        input  hold_low, probing, done, new_dendy, timed_out, mismatch_cnt
    );

    modport slave (
        input  rd_evt, rd_a13, rd_not_a13, force_mode, redetect,
        output hold_low, probing, done, new_dendy, timed_out, mismatch_cnt
    );
endinterface

// File: rtl/console_type_detector.sv
// console_type_detector: holds CIRAM/A13 low, then probes PPU reads to classify classic vs new famiclone
module console_type_detector #(
    parameter int INIT_CYCLES        = 15,
    parameter int SAMPLES_PER_LEVEL  = 2,
    parameter int MISMATCH_THRESHOLD = 1,
    parameter int TIMEOUT_CYCLES     = 0,
    parameter int MCNT_W             = 3
) (
    input logic m2,
    input logic rst_n,
    console_type_detector_if.slave bus
);
    localparam int IW = $clog2(INIT_CYCLES + 1);
    localparam int LW = $clog2(SAMPLES_PER_LEVEL + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [IW-1:0]     INIT_LAST = IW'(INIT_CYCLES - 1);
    localparam logic [LW-1:0]     SPL       = LW'(SAMPLES_PER_LEVEL);
    localparam logic [TW-1:0]     TMO       = TW'(TIMEOUT_CYCLES);
    localparam logic [MCNT_W-1:0] MMAX      = '1;

    typedef enum logic [1:0] {INIT, PROBE, DONE} state_t;

    state_t            state, state_nx;
    logic [IW-1:0]     icnt, icnt_nx;
    logic [LW-1:0]     lvl0, lvl0_nx, lvl1, lvl1_nx;
    logic [TW-1:0]     tcnt, tcnt_nx;
    logic [MCNT_W-1:0] mcnt, mcnt_nx;
    logic              dec, dec_nx, tout, tout_nx;
    logic              take, full, expire;

    always_ff @(posedge m2) begin
        if (!rst_n) state <= INIT;
        else        state <= state_nx;
    end

    always_ff @(posedge m2) begin
        if (!rst_n) begin
            icnt <= '0;
            lvl0 <= '0;
            lvl1 <= '0;
            tcnt <= '0;
            mcnt <= '0;
            dec  <= 1'b0;
            tout <= 1'b0;
        end else begin
            icnt <= icnt_nx;
            lvl0 <= lvl0_nx;
            lvl1 <= lvl1_nx;
            tcnt <= tcnt_nx;
            mcnt <= mcnt_nx;
            dec  <= dec_nx;
            tout <= tout_nx;
        end
    end

    // Events at a level that already has its quota are dropped, mismatches included.
    always_comb begin
        state_nx = state;
        icnt_nx  = icnt;
        lvl0_nx  = lvl0;
        lvl1_nx  = lvl1;
        tcnt_nx  = tcnt;
        mcnt_nx  = mcnt;
        dec_nx   = dec;
        tout_nx  = tout;
        full     = 1'b0;
        expire   = 1'b0;
        take     = bus.rd_evt && (bus.rd_a13 ? lvl1 < SPL : lvl0 < SPL);
        if (bus.redetect) begin
            state_nx = INIT;
            icnt_nx  = '0;
            lvl0_nx  = '0;
            lvl1_nx  = '0;
            tcnt_nx  = '0;
            mcnt_nx  = '0;
            dec_nx   = 1'b0;
            tout_nx  = 1'b0;
        end else if (state == INIT) begin
            icnt_nx  = icnt == INIT_LAST ? icnt : icnt + 1'b1;
            state_nx = icnt == INIT_LAST ? PROBE : INIT;
        end else if (state == PROBE) begin
            lvl0_nx = lvl0 + LW'(take && !bus.rd_a13);
            lvl1_nx = lvl1 + LW'(take && bus.rd_a13);
            mcnt_nx = mcnt + MCNT_W'(take && (bus.rd_a13 == bus.rd_not_a13) && mcnt != MMAX);
            tcnt_nx = tcnt + TW'(tcnt != TMO);
            full    = lvl0_nx == SPL && lvl1_nx == SPL;
            expire  = TIMEOUT_CYCLES != 0 && tcnt_nx == TMO;
            if (full || expire) begin
                state_nx = DONE;
                dec_nx   = int'(mcnt_nx) >= MISMATCH_THRESHOLD;
                tout_nx  = !full;
            end
        end
    end

    assign bus.hold_low     = state == INIT;
    assign bus.probing      = state == PROBE;
    assign bus.done         = state == DONE;
    assign bus.timed_out    = tout;
    assign bus.mismatch_cnt = mcnt;
    assign bus.new_dendy    = state == DONE &&
                              (bus.force_mode == 2'b01 ? 1'b0 :
                               bus.force_mode == 2'b10 ? 1'b1 : dec);
endmodule

// File: tb/tb_console_type_detector.sv
// tb_console_type_detector: scoreboard bench over three parameter sets sharing one stimulus stream
module tb_console_type_detector;
    typedef struct packed {
        logic       hold_low;
        logic       probing;
        logic       done;
        logic       new_dendy;
        logic       timed_out;
        logic [2:0] mcnt;
    } obs_t;

    typedef struct {
        int         d;
        logic       nd;
        logic       to;
        logic [2:0] m;
    } exp_t;

    logic       m2 = 1'b0;
    logic       rst_n, rd_evt, rd_a13, rd_not_a13, redetect;
    logic [1:0] force_mode;
    obs_t       ob [3];
    exp_t       sb [$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         n;

    always #5 m2 = ~m2;

    for (genvar g = 0; g < 3; g++) begin : u
        console_type_detector_if #(.MCNT_W(3)) bus ();
        assign bus.rd_evt     = rd_evt;
        assign bus.rd_a13     = rd_a13;
        assign bus.rd_not_a13 = rd_not_a13;
        assign bus.force_mode = force_mode;
        assign bus.redetect   = redetect;
        assign ob[g] = {bus.hold_low, bus.probing, bus.done, bus.new_dendy, bus.timed_out, bus.mismatch_cnt};
        console_type_detector #(
            .INIT_CYCLES(15),
            .SAMPLES_PER_LEVEL(g == 1 ? 3 : 2),
            .MISMATCH_THRESHOLD(g == 1 ? 2 : 1),
            .TIMEOUT_CYCLES(g == 2 ? 20 : 0),
            .MCNT_W(3)
        ) dut (
            .m2(m2),
            .rst_n(rst_n),
            .bus(bus)
        );
    end

    task automatic check(string tag, int got, int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge m2);
        #1;
    endtask

    task automatic evt(logic a, logic na);
        rd_evt     = 1'b1;
        rd_a13     = a;
        rd_not_a13 = na;
        tick();
        rd_evt     = 1'b0;
    endtask

    task automatic do_reset;
        int k;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        k = 0;
        while (!ob[0].probing && k < 100) begin
            tick();
            k++;
        end
        check("probe_entry", ob[0].probing, 1);
    endtask

    task automatic expect_result(int d, logic nd, logic to, logic [2:0] m);
        exp_t e;
        e.d  = d;
        e.nd = nd;
        e.to = to;
        e.m  = m;
        sb.push_back(e);
    endtask

    task automatic drain;
        while (sb.size() != 0) begin
            exp_t e;
            int   k;
            e = sb.pop_front();
            k = 0;
            while (!ob[e.d].done && k < 100) begin
                tick();
                k++;
            end
            check($sformatf("done%0d", e.d), ob[e.d].done, 1);
            check($sformatf("new_dendy%0d", e.d), ob[e.d].new_dendy, e.nd);
            check($sformatf("timed_out%0d", e.d), ob[e.d].timed_out, e.to);
            check($sformatf("mcnt%0d", e.d), ob[e.d].mcnt, e.m);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        rd_evt     = 1'b0;
        rd_a13     = 1'b0;
        rd_not_a13 = 1'b0;
        redetect   = 1'b0;
        force_mode = 2'b00;
        tick();
        tick();
        check("rst_hold_low", ob[0].hold_low, 1);
        check("rst_probing", ob[0].probing, 0);
        check("rst_done", ob[0].done, 0);
        check("rst_new_dendy", ob[0].new_dendy, 0);
        check("rst_timed_out", ob[0].timed_out, 0);
        check("rst_mcnt", ob[0].mcnt, 0);
        rst_n = 1'b1;
        n = 0;
        while (ob[0].hold_low && n < 100) begin
            n++;
            tick();
        end
        check("init_len", n, 15);
        check("init_probing", ob[0].probing, 1);
        repeat (60) tick();
        check("no_timeout", ob[0].done, 0);

        do_reset();
        expect_result(0, 1'b0, 1'b0, 3'd0);
        evt(0, 1);
        evt(1, 0);
        evt(0, 1);
        check("lat_before", ob[0].done, 0);
        evt(1, 0);
        check("lat_after", ob[0].done, 1);
        drain();

        do_reset();
        expect_result(0, 1'b1, 1'b0, 3'd1);
        evt(0, 1);
        evt(1, 1);
        evt(0, 1);
        evt(1, 0);
        drain();

        do_reset();
        expect_result(1, 1'b0, 1'b0, 3'd1);
        evt(0, 1);
        evt(1, 0);
        evt(0, 1);
        evt(1, 0);
        evt(0, 0);
        evt(0, 0);
        evt(0, 0);
        check("full_level_open", ob[1].done, 0);
        check("full_level_mcnt", ob[1].mcnt, 1);
        evt(1, 0);
        drain();

        do_reset();
        expect_result(2, 1'b1, 1'b1, 3'd1);
        evt(0, 0);
        n = 1;
        while (!ob[2].done && n < 100) begin
            tick();
            n++;
        end
        check("tmo_len", n, 20);
        check("no_tmo_dut0", ob[0].done, 0);
        drain();

        force_mode = 2'b01;
        #1;
        check("force01", ob[2].new_dendy, 0);
        force_mode = 2'b10;
        #1;
        check("force10", ob[2].new_dendy, 1);
        check("force_probe_dut0", ob[0].new_dendy, 0);
        force_mode = 2'b00;
        #1;
        check("force_release", ob[2].new_dendy, 1);
        redetect   = 1'b1;
        rd_evt     = 1'b1;
        rd_a13     = 1'b0;
        rd_not_a13 = 1'b0;
        tick();
        redetect   = 1'b0;
        rd_evt     = 1'b0;
        check("redet_done", ob[2].done, 0);
        check("redet_hold_low", ob[2].hold_low, 1);
        check("redet_mcnt", ob[2].mcnt, 0);
        check("redet_timed_out", ob[2].timed_out, 0);
        check("redet_mcnt_dut0", ob[0].mcnt, 0);
        n = 0;
        while (ob[2].hold_low && n < 100) begin
            n++;
            tick();
        end
        check("reinit_len", n, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
